// File: rtl/div_sequencer.sv
// div_sequencer: FIFO-buffered request front end that drives one external iterative divider op at a time.
// Define DIV_SIGNED_EN to enable two's-complement operand handling; otherwise req_signed is ignored.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_op,
  input  logic             req_signed,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_dbz,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_op,
  input  logic             div_end,
  input  logic [WIDTH-1:0] div_result
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [DEPTH-1:0] mem_op;
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, empty, push, pop;
  logic [WIDTH-1:0] head_a, head_b, mag_a, mag_b, fixed;
  logic head_op, neg_a, neg_b, dbz, ovf, sa, sb;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign req_ready = rst_n && !full;
  assign push = req_valid && req_ready;
  assign pop = (state == IDLE) && !empty;
  assign head_a = mem_a[rd_ptr[AW-1:0]];
  assign head_b = mem_b[rd_ptr[AW-1:0]];
  assign head_op = mem_op[rd_ptr[AW-1:0]];
  assign dbz = head_b == '0;
`ifdef DIV_SIGNED_EN
  logic [DEPTH-1:0] mem_sg;
  logic head_sg;
  assign head_sg = mem_sg[rd_ptr[AW-1:0]];
  assign neg_a = head_sg && head_a[WIDTH-1];
  assign neg_b = head_sg && head_b[WIDTH-1];
  assign ovf = head_sg && (head_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&head_b);
  always_ff @(posedge clk)
    if (push) mem_sg[wr_ptr[AW-1:0]] <= req_signed;
`else
  logic unused;
  assign unused = req_signed;
  assign neg_a = 1'b0;
  assign neg_b = 1'b0;
  assign ovf = 1'b0;
`endif
  assign mag_a = neg_a ? -head_a : head_a;
  assign mag_b = neg_b ? -head_b : head_b;
  // quotient sign follows sign(a)^sign(b); remainder sign follows the dividend
  assign fixed = (div_op ? (sa ^ sb) : sa) ? -div_result : div_result;
  assign rsp_valid = state == DONE;
  assign div_start = state == START;
  always_ff @(posedge clk)
    if (push) begin
      mem_a[wr_ptr[AW-1:0]] <= req_a;
      mem_b[wr_ptr[AW-1:0]] <= req_b;
      mem_op[wr_ptr[AW-1:0]] <= req_op;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rsp_data <= '0;
      rsp_dbz <= 1'b0;
      div_a <= '0;
      div_b <= '0;
      div_op <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        div_a <= mag_a;
        div_b <= mag_b;
        div_op <= head_op;
        sa <= neg_a;
        sb <= neg_b;
        rsp_dbz <= dbz;
        rsp_data <= dbz ? (head_op ? '1 : head_a) : (head_op ? head_a : '0);
        state <= (dbz || ovf) ? DONE : START;
      end else if (state == START) state <= WAIT;
      else if (state == WAIT && div_end) begin
        rsp_data <= fixed;
        state <= DONE;
      end else if (state == DONE && rsp_ready) state <= IDLE;
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: scoreboard bench with a behavioural divider of random latency on the divider side.
module tb_div_sequencer;
  localparam int W = 32;
  localparam int CW = W + 1;
`ifdef DIV_SIGNED_EN
  localparam bit SG_EN = 1'b1;
`else
  localparam bit SG_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_op = 1'b0, req_signed = 1'b0;
  logic rsp_ready = 1'b1, div_end = 1'b0;
  logic [W-1:0] req_a = '0, req_b = '0, div_result = '0;
  logic req_ready, rsp_valid, rsp_dbz, div_start, div_op;
  logic [W-1:0] rsp_data, div_a, div_b;
  int passed = 0, total = 0, starts = 0, gen = 0, s0 = 0, acc = 0;
  bit slow = 1'b0;
  logic [W-1:0] last_div_a = '0, dv_a, dv_b;
  logic dv_op;
  int dv_g, dv_lat;
  logic [W:0] exp_q [$];

  always #5 clk = ~clk;

  div_sequencer #(.WIDTH(W), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_signed(req_signed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_dbz(rsp_dbz),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_op(div_op),
    .div_end(div_end), .div_result(div_result)
  );

  task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic sg);
    logic [W-1:0] mn;
    mn = {1'b1, {(W-1){1'b0}}};
    if (b == '0) return {1'b1, op ? {W{1'b1}} : a};
    if (SG_EN && sg) begin
      if (a == mn && b == {W{1'b1}}) return {1'b0, op ? a : {W{1'b0}}};
      return {1'b0, op ? $signed(a) / $signed(b) : $signed(a) % $signed(b)};
    end
    return {1'b0, op ? a / b : a % b};
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op, input logic sg);
    int n = 0;
    req_a = a; req_b = b; req_op = op; req_signed = sg; req_valid = 1'b1;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("send_ready", CW'(req_ready), CW'(1));
    if (req_ready) exp_q.push_back(model(a, b, op, sg));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("drain", CW'(exp_q.size()), CW'(0));
    @(negedge clk);
  endtask

  // divider partner: captures operands on the start pulse, answers after a random latency
  initial forever begin
    @(negedge clk);
    if (rst_n && div_start) begin
      dv_a = div_a; dv_b = div_b; dv_op = div_op; dv_g = gen;
      last_div_a = div_a;
      starts++;
      dv_lat = slow ? 30 : int'($urandom_range(1, 4));
      @(negedge clk);
      chk("start_pulse", CW'(div_start), CW'(0));
      chk("div_a_stable", CW'(div_a), CW'(dv_a));
      repeat (dv_lat - 1) @(negedge clk);
      if (gen == dv_g) begin
        div_result = dv_op ? dv_a / dv_b : dv_a % dv_b;
        div_end = 1'b1;
        @(negedge clk);
        div_end = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && rsp_valid && rsp_ready) begin
      chk("rsp_pending", CW'(exp_q.size() != 0), CW'(1));
      if (exp_q.size() != 0) chk("rsp", {rsp_dbz, rsp_data}, exp_q.pop_front());
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", CW'(rsp_valid), CW'(0));
    chk("rst_req_ready", CW'(req_ready), CW'(0));
    chk("rst_div_start", CW'(div_start), CW'(0));
    chk("rst_rsp_data", {rsp_dbz, rsp_data}, CW'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", CW'(req_ready), CW'(1));
    s0 = starts;
    send(100, 7, 1'b1, 1'b0);
    send(100, 7, 1'b0, 1'b0);
    drain();
    chk("starts_100_7", CW'(starts - s0), CW'(2));
    send(32'hFFFF_FFF9, 2, 1'b1, 1'b1);
    send(32'hFFFF_FFF9, 2, 1'b0, 1'b1);
    drain();
    chk("div_a_neg7", CW'(last_div_a), SG_EN ? CW'(7) : CW'(32'hFFFF_FFF9));
    s0 = starts;
    send(5, 0, 1'b1, 1'b0);
    send(5, 0, 1'b0, 1'b1);
    drain();
    chk("dbz_no_start", CW'(starts - s0), CW'(0));
    s0 = starts;
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    drain();
    chk("ovf_starts", CW'(starts - s0), SG_EN ? CW'(0) : CW'(1));
    for (int i = 0; i < 10; i++)
      send($urandom, W'($urandom_range(0, 40)) - W'(i[0] ? 20 : 0), 1'($urandom), 1'($urandom));
    drain();
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_a = W'(200 + i); req_b = W'(3 + i); req_op = i[0]; req_signed = 1'b0; req_valid = 1'b1;
      if (req_ready) begin exp_q.push_back(model(req_a, req_b, req_op, 1'b0)); acc++; end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bp_accepted", CW'(acc), CW'(5));
    chk("bp_ready_low", CW'(req_ready), CW'(0));
    for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
    chk("bp_valid_held", CW'(rsp_valid), CW'(1));
    repeat (3) @(negedge clk);
    chk("bp_hold_data", {rsp_dbz, rsp_data}, exp_q[0]);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();
    chk("bp_ready_back", CW'(req_ready), CW'(1));
    slow = 1'b1;
    send(100, 7, 1'b1, 1'b0);
    send(9, 2, 1'b1, 1'b0);
    for (int n = 0; n < 20 && !div_start; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    gen++;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", CW'(rsp_valid), CW'(0));
    chk("mid_rst_data", {rsp_dbz, rsp_data}, CW'(0));
    chk("mid_rst_div_ab", {1'b0, div_a | div_b}, CW'(0));
    chk("mid_rst_ctrl", CW'({div_op, div_start, req_ready}), CW'(0));
    slow = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_stray_rsp", CW'(rsp_valid), CW'(0));
    send(12, 5, 1'b0, 1'b0);
    send(12, 5, 1'b1, 1'b0);
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (>= 4).
REQ-002 SHALL have parameter DEPTH, default 4, request FIFO entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports req_valid input 1 / req_ready output 1  request handshake.
REQ-006 SHALL have ports req_a input WIDTH (dividend), req_b input WIDTH (divisor).
REQ-007 SHALL have ports req_op input 1 (1 quotient, 0 remainder), req_signed input 1 (two's-complement operands).
REQ-008 SHALL have ports rsp_valid output 1 / rsp_ready input 1  response handshake.
REQ-009 SHALL have ports rsp_data output WIDTH (result), rsp_dbz output 1 (divisor was zero).
REQ-010 SHALL have divider-side ports: div_start output 1, div_a output WIDTH, div_b output WIDTH, div_op output 1, div_end input 1, div_result input WIDTH.

Function
REQ-011 SHALL buffer requests in a DEPTH-entry FIFO; req_ready = !full; push on req_valid && req_ready; push blocked when full even if pop occurs same cycle.
REQ-012 SHALL run FSM IDLE, START, WAIT, DONE; exactly one operation in flight.
REQ-013 IDLE: if FIFO non-empty, SHALL pop head; if divisor zero or signed overflow (REQ-018/019) -> DONE with bypass result; else -> START.
REQ-014 On pop SHALL latch div_a/div_b as operand magnitudes (absolute value when signed, else raw), div_op = req_op, plus signs of a and b.
REQ-015 START: div_start SHALL be 1 for exactly one cycle; -> WAIT; div_a/div_b/div_op SHALL stay stable from START until WAIT exits.
REQ-016 WAIT: on clock edge with div_end = 1 SHALL capture div_result, apply sign fix, -> DONE; div_end outside WAIT SHALL be ignored.
REQ-017 Sign fix (signed only): quotient negated iff sign(a) != sign(b); remainder negated iff a negative; unsigned passes through.
REQ-018 Divisor zero: rsp_dbz = 1; quotient = all ones; remainder = req_a; divider not started.
REQ-019 Signed overflow (a = most-negative, b = all ones): quotient = a, remainder = 0, rsp_dbz = 0, divider not started.
REQ-020 DONE: rsp_valid = 1; rsp_data/rsp_dbz SHALL hold stable until rsp_ready; on rsp_valid && rsp_ready -> IDLE.
REQ-021 Latency pop-to-rsp_valid: bypass 1 cycle; normal = 2 + divider cycles (START, WAIT..div_end edge).

Reset
REQ-022 rst_n low SHALL immediately force: FSM IDLE, FIFO empty, req_ready 0 while in reset, rsp_valid 0, rsp_data 0, rsp_dbz 0, div_start 0, div_a 0, div_b 0, div_op 0.
REQ-023 Reset mid-operation SHALL discard the in-flight op and all queued requests; the unreset divider is re-initialised by the next div_start.

Configuration
REQ-024 Macro DIV_SIGNED_EN defined: signed handling per REQ-014/017/019 active.
REQ-025 DIV_SIGNED_EN undefined: req_signed ignored, all operands unsigned, overflow bypass and sign fix absent; divide-by-zero bypass retained.

Verification
REQ-026 Unsigned a=100, b=7, op=1 -> rsp_data 14; op=0 -> 2; one div_start pulse each.
REQ-027 Signed a=0xFFFFFFF9 (-7), b=2: op=1 -> 0xFFFFFFFD; op=0 -> 0xFFFFFFFF; div_a = 7.
REQ-028 a=5, b=0, op=1 -> 0xFFFFFFFF, rsp_dbz 1; op=0 -> 5; div_start never asserted.
REQ-029 Signed 0x80000000 / 0xFFFFFFFF, op=1 -> 0x80000000, no div_start; without DIV_SIGNED_EN -> divider used, result 0.
REQ-030 rsp_ready held 0, 6 back-to-back requests -> 5 accepted (1 in flight + 4 queued), req_ready low; releasing rsp_ready drains in order.
REQ-031 rst_n low during WAIT -> outputs zero, FIFO empty; next request after reset completes correctly.
